bsg_fpu_f2i_pipe: RTL and testbench

//  Pipelined, parametrised float-to-integer converter with a valid/ready handshake.

---
 rtl/bsg_fpu_pkg.sv | 27 ++
 rtl/bsg_fpu_f2i_round.sv | 26 ++
 rtl/bsg_fpu_f2i_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_bsg_fpu_f2i_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bsg_fpu_pkg.sv
// Shared types for the float-to-integer converter: rounding modes, flag bundle
// and the operand class carried from the decode stage to the round stage.
package bsg_fpu_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef struct packed {
        logic nv;
        logic nx;
    } f2i_flags_s;

    // CLS_OVF means the magnitude is already >= 2^width_p before rounding.
    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_NUM  = 3'd1,
        CLS_INF  = 3'd2,
        CLS_NAN  = 3'd3,
        CLS_OVF  = 3'd4
    } f2i_cls_e;

endpackage

// File: rtl/bsg_fpu_f2i_round.sv
// Round-increment decision from the retained lsb, the first discarded bit
// (guard), the OR of all lower discarded bits (sticky), sign and rounding mode.
module bsg_fpu_f2i_round
    import bsg_fpu_pkg::*;
(
    input  logic       lsb_i,
    input  logic       guard_i,
    input  logic       sticky_i,
    input  logic       sign_i,
    input  logic [2:0] rm_i,
    output logic       round_up_o
);

    always_comb begin
        round_up_o = 1'b0;
        case (rm_i)
            RM_RTZ:  round_up_o = 1'b0;
            RM_RDN:  round_up_o = sign_i & (guard_i | sticky_i);
            RM_RUP:  round_up_o = ~sign_i & (guard_i | sticky_i);
            RM_RMM:  round_up_o = guard_i;
            // RNE and the reserved encodings 5-7
            default: round_up_o = guard_i & (sticky_i | lsb_i);
        endcase
    end

endmodule

// File: rtl/bsg_fpu_f2i_pipe.sv
// Two-stage float-to-integer converter with valid/ready flow control.
// Optional sticky flag accumulator: define BSG_FPU_F2I_STICKY_FLAGS_EN.
module bsg_fpu_f2i_pipe
    import bsg_fpu_pkg::*;
#(
    parameter int e_p     = 8,
    parameter int m_p     = 23,
    parameter int width_p = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 v_i,
    output logic                 ready_and_o,
    input  logic [e_p+m_p:0]     a_i,
    input  logic                 signed_i,
    input  logic [2:0]           rm_i,
    output logic                 v_o,
    input  logic                 ready_and_i,
    output logic [width_p-1:0]   z_o,
    output logic                 nv_o,
`ifdef BSG_FPU_F2I_STICKY_FLAGS_EN
    input  logic                 clear_flags_i,
    output logic [1:0]           fflags_o,
`endif
    output logic                 nx_o
);

    localparam int FW   = e_p + m_p + 1;
    localparam int BIAS = (1 << (e_p - 1)) - 1;
    // width_p integer bits, one guard bit, m_p+1 sticky bits
    localparam int L    = width_p + m_p + 2;
    localparam int SHW  = $clog2(L + 1);

    // Handshake: a stage loads when empty or when its successor drains it.
    logic s1_v_q, s2_v_q, s1_ready, s2_ready;
    assign s2_ready    = ~s2_v_q | ready_and_i;
    assign s1_ready    = ~s1_v_q | s2_ready;
    assign ready_and_o = reset_n_i & s1_ready;
    assign v_o         = s2_v_q;

    // Stage 1: decode and classify
    logic             sign_in;
    logic [e_p-1:0]   exp_in;
    logic [m_p-1:0]   man_in;
    int               sh_full;
    f2i_cls_e         s1_cls_d, s1_cls_q;
    logic [SHW-1:0]   s1_sh_d, s1_sh_q;
    logic [m_p:0]     s1_sig_q;
    logic             s1_sign_q, s1_signed_q;
    logic [2:0]       s1_rm_q;

    assign sign_in = a_i[FW-1];
    assign exp_in  = a_i[FW-2 -: e_p];
    assign man_in  = a_i[m_p-1:0];

    // Denormals use exponent 1 with a zero hidden bit, so they flow through
    // the same shifter as normals.
    always_comb begin
        s1_cls_d = CLS_NUM;
        s1_sh_d  = '0;
        sh_full  = BIAS + width_p - 1 - ((exp_in == '0) ? 1 : int'(exp_in));
        if (&exp_in) begin
            s1_cls_d = (man_in != '0) ? CLS_NAN : CLS_INF;
        end else if (exp_in == '0 && man_in == '0) begin
            s1_cls_d = CLS_ZERO;
        end else if (sh_full < 0) begin
            s1_cls_d = CLS_OVF;
        end else if (sh_full >= L) begin
            s1_sh_d = SHW'(L);
        end else begin
            s1_sh_d = sh_full[SHW-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v_q      <= 1'b0;
            s1_cls_q    <= CLS_ZERO;
            s1_sh_q     <= '0;
            s1_sig_q    <= '0;
            s1_sign_q   <= 1'b0;
            s1_signed_q <= 1'b0;
            s1_rm_q     <= '0;
        end else begin
            if (s1_ready) s1_v_q <= v_i;
            if (v_i & ready_and_o) begin
                s1_cls_q    <= s1_cls_d;
                s1_sh_q     <= s1_sh_d;
                s1_sig_q    <= {(exp_in != '0), man_in};
                s1_sign_q   <= sign_in;
                s1_signed_q <= signed_i;
                s1_rm_q     <= rm_i;
            end
        end
    end

    // Stage 2: align, round, range-check, saturate
    logic [L-1:0]       sig_ext, shifted, lost_mask;
    logic [width_p-1:0] int_part, pos_sat, neg_sat;
    logic [width_p:0]   mag;
    logic               guard, sticky, round_up, in_range;
    logic [width_p-1:0] z_d, z_q;
    logic               nv_d, nx_d, nv_q, nx_q;

    assign sig_ext   = {s1_sig_q, {(width_p + 1){1'b0}}};
    assign shifted   = sig_ext >> s1_sh_q;
    assign lost_mask = ~({L{1'b1}} << s1_sh_q);
    assign int_part  = shifted[L-1 -: width_p];
    assign guard     = shifted[m_p+1];
    assign sticky    = (|shifted[m_p:0]) | (|(sig_ext & lost_mask));

    bsg_fpu_f2i_round round_u (
        .lsb_i      (int_part[0]),
        .guard_i    (guard),
        .sticky_i   (sticky),
        .sign_i     (s1_sign_q),
        .rm_i       (s1_rm_q),
        .round_up_o (round_up)
    );

    // One spare bit catches a rounding carry out of the integer field.
    assign mag     = {1'b0, int_part} + {{width_p{1'b0}}, round_up};
    assign pos_sat = s1_signed_q ? {1'b0, {(width_p - 1){1'b1}}} : {width_p{1'b1}};
    assign neg_sat = s1_signed_q ? {1'b1, {(width_p - 1){1'b0}}} : {width_p{1'b0}};

    always_comb begin
        z_d      = '0;
        nv_d     = 1'b0;
        nx_d     = 1'b0;
        in_range = 1'b0;
        case (s1_cls_q)
            CLS_ZERO: ;
            CLS_NAN: begin
                z_d  = pos_sat;
                nv_d = 1'b1;
            end
            CLS_INF, CLS_OVF: begin
                z_d  = s1_sign_q ? neg_sat : pos_sat;
                nv_d = 1'b1;
            end
            default: begin
                if (s1_sign_q) begin
                    // signed accepts magnitudes up to 2^(w-1); unsigned only 0
                    in_range = s1_signed_q
                        ? (~mag[width_p] & (~mag[width_p-1] | ~(|mag[width_p-2:0])))
                        : (mag == '0);
                end else begin
                    in_range = ~mag[width_p] & (~s1_signed_q | ~mag[width_p-1]);
                end
                if (in_range) begin
                    z_d  = s1_sign_q ? -mag[width_p-1:0] : mag[width_p-1:0];
                    nx_d = guard | sticky;
                end else begin
                    z_d  = s1_sign_q ? neg_sat : pos_sat;
                    nv_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s2_v_q <= 1'b0;
            z_q    <= '0;
            nv_q   <= 1'b0;
            nx_q   <= 1'b0;
        end else begin
            if (s2_ready) s2_v_q <= s1_v_q;
            if (s2_ready & s1_v_q) begin
                z_q  <= z_d;
                nv_q <= nv_d;
                nx_q <= nx_d;
            end
        end
    end

    assign z_o  = z_q;
    assign nv_o = nv_q;
    assign nx_o = nx_q;

`ifdef BSG_FPU_F2I_STICKY_FLAGS_EN
    f2i_flags_s hs_flags;
    logic [1:0] fflags_q;
    assign hs_flags = '{nv: nv_q, nx: nx_q};

    // A handshake coinciding with a clear loads only the new flags.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fflags_q <= 2'b00;
        end else if (v_o & ready_and_i) begin
            fflags_q <= clear_flags_i ? hs_flags : (fflags_q | hs_flags);
        end else if (clear_flags_i) begin
            fflags_q <= 2'b00;
        end
    end

    assign fflags_o = fflags_q;
`endif

endmodule

// File: tb/tb_bsg_fpu_f2i_pipe.sv
// Directed bench for bsg_fpu_f2i_pipe at fp32 -> int32: rounding, saturation,
// backpressure, mid-stream reset and (when enabled) sticky flags.
module tb_bsg_fpu_f2i_pipe;
    import bsg_fpu_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        v_i, ready_and_o, signed_i, v_o, ready_and_i, nv_o, nx_o;
    logic [31:0] a_i, z_o;
    logic [2:0]  rm_i;
`ifdef BSG_FPU_F2I_STICKY_FLAGS_EN
    logic        clear_flags_i;
    logic [1:0]  fflags_o;
`endif

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    logic [31:0] bp_ops [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] bp_res [4] = '{32'd1, 32'd2, 32'd3, 32'd4};

    always #5 clk_i = ~clk_i;

    bsg_fpu_f2i_pipe dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .v_i           (v_i),
        .ready_and_o   (ready_and_o),
        .a_i           (a_i),
        .signed_i      (signed_i),
        .rm_i          (rm_i),
        .v_o           (v_o),
        .ready_and_i   (ready_and_i),
        .z_o           (z_o),
        .nv_o          (nv_o),
`ifdef BSG_FPU_F2I_STICKY_FLAGS_EN
        .clear_flags_i (clear_flags_i),
        .fflags_o      (fflags_o),
`endif
        .nx_o          (nx_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One op through an idle pipe: accept, one empty cycle, then the result.
    task automatic run_vec(input string tag, input logic [31:0] a, input logic sgn,
                           input logic [2:0] rm, input logic [31:0] ez,
                           input logic env, input logic enx);
        @(posedge clk_i); #1;
        v_i = 1'b1; a_i = a; signed_i = sgn; rm_i = rm; ready_and_i = 1'b1;
        #1 check({tag, "/rdy"}, ready_and_o, 32'd1);
        @(posedge clk_i); #1;
        v_i = 1'b0;
        check({tag, "/v_lat1"}, v_o, 32'd0);
        @(posedge clk_i); #1;
        check({tag, "/v_lat2"}, v_o, 32'd1);
        check({tag, "/z"}, z_o, ez);
        check({tag, "/nv"}, nv_o, env);
        check({tag, "/nx"}, nx_o, enx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int idx, outs;
        logic [31:0] prev_z;
        logic        prev_stall;

        reset_n_i = 1'b0; v_i = 1'b0; a_i = '0; signed_i = 1'b0;
        rm_i = RM_RNE; ready_and_i = 1'b1;
`ifdef BSG_FPU_F2I_STICKY_FLAGS_EN
        clear_flags_i = 1'b0;
`endif
        repeat (2) @(posedge clk_i);
        #1;
        check("rst/rdy", ready_and_o, 32'd0);
        check("rst/v_o", v_o, 32'd0);
        check("rst/z", z_o, 32'd0);
        check("rst/nv", nv_o, 32'd0);
        check("rst/nx", nx_o, 32'd0);
`ifdef BSG_FPU_F2I_STICKY_FLAGS_EN
        check("rst/fflags", fflags_o, 32'd0);
`endif
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // rounding of 2.5 and friends
        run_vec("2.5_rne", 32'h40200000, 1'b1, RM_RNE, 32'd2, 1'b0, 1'b1);
        run_vec("2.5_rtz", 32'h40200000, 1'b1, RM_RTZ, 32'd2, 1'b0, 1'b1);
        run_vec("2.5_rup", 32'h40200000, 1'b1, RM_RUP, 32'd3, 1'b0, 1'b1);
        run_vec("2.5_rmm", 32'h40200000, 1'b1, RM_RMM, 32'd3, 1'b0, 1'b1);
        run_vec("2.5_rm5", 32'h40200000, 1'b1, 3'd5,   32'd2, 1'b0, 1'b1);
        run_vec("1.0",     32'h3F800000, 1'b1, RM_RNE, 32'd1, 1'b0, 1'b0);
        run_vec("0.5_rne", 32'h3F000000, 1'b1, RM_RNE, 32'd0, 1'b0, 1'b1);
        run_vec("0.5_rmm", 32'h3F000000, 1'b1, RM_RMM, 32'd1, 1'b0, 1'b1);
        run_vec("3.75_u_rtz", 32'h40700000, 1'b0, RM_RTZ, 32'd3, 1'b0, 1'b1);
        run_vec("3.75_u_rne", 32'h40700000, 1'b0, RM_RNE, 32'd4, 1'b0, 1'b1);
        // negatives
        run_vec("-1.5_rdn", 32'hBFC00000, 1'b1, RM_RDN, 32'hFFFFFFFE, 1'b0, 1'b1);
        run_vec("-1.5_rne", 32'hBFC00000, 1'b1, RM_RNE, 32'hFFFFFFFE, 1'b0, 1'b1);
        run_vec("-2.5_rmm", 32'hC0200000, 1'b1, RM_RMM, 32'hFFFFFFFD, 1'b0, 1'b1);
        run_vec("-0.25_u_rtz", 32'hBE800000, 1'b0, RM_RTZ, 32'd0, 1'b0, 1'b1);
        run_vec("-0.25_u_rdn", 32'hBE800000, 1'b0, RM_RDN, 32'd0, 1'b1, 1'b0);
        // zeros and denormals
        run_vec("+0_u", 32'h00000000, 1'b0, RM_RNE, 32'd0, 1'b0, 1'b0);
        run_vec("-0_s", 32'h80000000, 1'b1, RM_RDN, 32'd0, 1'b0, 1'b0);
        run_vec("dn_rup", 32'h00000001, 1'b0, RM_RUP, 32'd1, 1'b0, 1'b1);
        run_vec("-dn_rdn", 32'h80000001, 1'b1, RM_RDN, 32'hFFFFFFFF, 1'b0, 1'b1);
        run_vec("-dn_rtz", 32'h80000001, 1'b1, RM_RTZ, 32'd0, 1'b0, 1'b1);
        // range boundaries and saturation
        run_vec("nan_s", 32'h7FC00000, 1'b1, RM_RNE, 32'h7FFFFFFF, 1'b1, 1'b0);
        run_vec("2^31_s", 32'h4F000000, 1'b1, RM_RNE, 32'h7FFFFFFF, 1'b1, 1'b0);
        run_vec("-2^31_s", 32'hCF000000, 1'b1, RM_RNE, 32'h80000000, 1'b0, 1'b0);
        run_vec("2^31_u", 32'h4F000000, 1'b0, RM_RNE, 32'h80000000, 1'b0, 1'b0);
        run_vec("max_u", 32'h4F7FFFFF, 1'b0, RM_RNE, 32'hFFFFFF00, 1'b0, 1'b0);
        run_vec("2^32_u", 32'h4F800000, 1'b0, RM_RNE, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_vec("+inf_u", 32'h7F800000, 1'b0, RM_RNE, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_vec("-inf_s", 32'hFF800000, 1'b1, RM_RNE, 32'h80000000, 1'b1, 1'b0);
        run_vec("-inf_u", 32'hFF800000, 1'b0, RM_RNE, 32'd0, 1'b1, 1'b0);

        // backpressure: four ops, consumer stalled for the first four cycles
        idx = 0; outs = 0; prev_z = '0; prev_stall = 1'b0;
        signed_i = 1'b1; rm_i = RM_RNE;
        for (int cyc = 0; cyc < 30 && outs < 4; cyc++) begin
            @(posedge clk_i); #1;
            ready_and_i = (cyc >= 4);
            if (idx < 4) begin
                v_i = 1'b1; a_i = bp_ops[idx];
            end else begin
                v_i = 1'b0;
            end
            #1;
            if (cyc == 2) begin
                check("bp/rdy_low", ready_and_o, 32'd0);
                check("bp/accepted", idx, 32'd2);
            end
            if (v_o && !ready_and_i && prev_stall) check("bp/hold", z_o, prev_z);
            if (v_o && ready_and_i) begin
                check("bp/q_nonempty", (exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("bp/z", z_o, exp_q.pop_front());
                outs++;
            end
            if (v_i && ready_and_o) begin
                exp_q.push_back(bp_res[idx]);
                idx++;
            end
            prev_stall = v_o && !ready_and_i;
            prev_z     = z_o;
        end
        v_i = 1'b0;
        check("bp/outs", outs, 32'd4);
        check("bp/q_empty", exp_q.size(), 32'd0);

        // reset with two ops in flight
        @(posedge clk_i); #1;
        ready_and_i = 1'b0; v_i = 1'b1; a_i = 32'h3F800000;
        @(posedge clk_i); #1;
        a_i = 32'h40000000;
        @(posedge clk_i); #1;
        v_i = 1'b0;
        check("mrst/inflight", v_o, 32'd1);
        #1 reset_n_i = 1'b0;
        #1;
        check("mrst/v_o", v_o, 32'd0);
        check("mrst/rdy", ready_and_o, 32'd0);
        check("mrst/z", z_o, 32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        run_vec("post_rst", 32'h40400000, 1'b1, RM_RNE, 32'd3, 1'b0, 1'b0);

`ifdef BSG_FPU_F2I_STICKY_FLAGS_EN
        run_vec("sf_nx", 32'h40200000, 1'b1, RM_RNE, 32'd2, 1'b0, 1'b1);
        run_vec("sf_nv", 32'h7FC00000, 1'b1, RM_RNE, 32'h7FFFFFFF, 1'b1, 1'b0);
        @(posedge clk_i); #1;
        check("sf/accum", fflags_o, 32'd3);
        clear_flags_i = 1'b1;
        @(posedge clk_i); #1;
        clear_flags_i = 1'b0;
        check("sf/clear", fflags_o, 32'd0);
        run_vec("sf_nv2", 32'h7FC00000, 1'b1, RM_RNE, 32'h7FFFFFFF, 1'b1, 1'b0);
        @(posedge clk_i); #1;
        run_vec("sf_nx2", 32'h40200000, 1'b1, RM_RNE, 32'd2, 1'b0, 1'b1);
        clear_flags_i = 1'b1;
        @(posedge clk_i); #1;
        clear_flags_i = 1'b0;
        check("sf/clear_hs", fflags_o, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
